// File: rtl/board_saver.sv
// Captures one generation of the Life board from the cell stream and serves it
// to the HPS as an ioctl upload, one byte per cell ({7'b0, alive}).
module board_saver #(
   parameter int CELLS = 2073600,
   parameter int DEPTH = 16
) (
   input  logic        CLK_50M,
   input  logic        RESET,
   input  logic        save_req,
   input  logic        frame_start,
   input  logic        cell_valid,
   input  logic        cell_bit,
   output logic        cell_hold,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [26:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err
);

   localparam int CW = $clog2(CELLS + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST    = CW'(CELLS);
   localparam logic [NW-1:0] FULL    = NW'(DEPTH);
   localparam logic [NW-1:0] HOLD_AT = NW'(DEPTH - 2);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

   state_t         state;
   // Only the alive bit is stored; the upper seven bits of every byte are zero.
   logic [DEPTH-1:0] mem;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [NW-1:0]  count;
   logic [CW-1:0]  cell_cnt;
   logic [CW-1:0]  rd_cnt;

   logic active;
   logic abort;
   logic push_req;
   logic last_push;
   logic pop;
   logic push;
   logic drop;
   logic rd_empty;
   logic addr_bad;
   logic complete;

   assign active    = (state != IDLE);
   assign abort     = active && !ioctl_upload;
   assign push_req  = cell_valid && ((state == CAPTURE) || ((state == ARM) && frame_start));
   assign last_push = push_req && (cell_cnt == LAST - CW'(1));
   assign pop       = active && ioctl_rd && (count != '0);
   assign push      = push_req && ((count != FULL) || pop);
   assign drop      = push_req && (count == FULL) && !pop;
   assign rd_empty  = active && ioctl_rd && (count == '0);
   assign addr_bad  = pop && (ioctl_addr != 27'(rd_cnt));
   assign complete  = (state == DRAIN) && (count == '0) && (rd_cnt == LAST);

   // Dropped cells still count toward CELLS, so a lossy capture ends in DRAIN
   // without ever completing; only an upload abort gets it back to IDLE.
   always_ff @(posedge CLK_50M or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         mem       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cell_cnt  <= '0;
         rd_cnt    <= '0;
         cell_hold <= 1'b0;
         ioctl_din <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 2'b00;
      end else begin
         done      <= 1'b0;
         cell_hold <= (count >= HOLD_AT);
         ioctl_din <= (count != '0) ? {7'b0, mem[rd_ptr]} : 8'h00;
         if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (save_req && ioctl_upload) begin
                     state    <= ARM;
                     busy     <= 1'b1;
                     err      <= 2'b00;
                     cell_cnt <= '0;
                     rd_cnt   <= '0;
                     wr_ptr   <= '0;
                     rd_ptr   <= '0;
                     count    <= '0;
                  end
               end
               ARM: begin
                  if (frame_start) state <= last_push ? DRAIN : CAPTURE;
               end
               CAPTURE: begin
                  if (last_push) state <= DRAIN;
               end
               DRAIN: begin
                  if (complete) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
            if (push) begin
               mem[wr_ptr] <= cell_bit;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
               rd_cnt <= rd_cnt + CW'(1);
            end
            if (push_req) cell_cnt <= cell_cnt + CW'(1);
            if (push && !pop) count <= count + NW'(1);
            else if (pop && !push) count <= count - NW'(1);
            if (drop) err[0] <= 1'b1;
            if (rd_empty || addr_bad) err[1] <= 1'b1;
         end
      end
   end

endmodule
